pad_row_builder: RTL and testbench

- Upstream stage of the 3-row padding register.
- Accepts a raster RGB pixel stream of an IMG_H x IMG_W frame and assembles zero-padded rows of IMG_W+2 pixels per channel.
- Per frame, emits IMG_H+2 rows on the R/G/B_padded buses: one all-zero top row, IMG_H image rows, one all-zero bottom row.
- Gives the 3x3 convolution front-end its 1-pixel zero border.

---
 rtl/pad_pkg.sv | 27 ++
 rtl/pad_row_buffer.sv | 63 ++++++
 rtl/pad_row_builder.sv | 139 +++++++++++++
 tb/tb_pad_row_builder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_pkg.sv
// Shared definitions for the zero-padded row builder.
//   DEF_IMG_W / DEF_IMG_H / DEF_PIX_W : default frame geometry and sample width
//   row_width()                       : bits in one padded row of one channel
//   DEF_ROW_W                         : padded row width for the default geometry
//   state_t                           : row builder FSM states
package pad_pkg;

  localparam int DEF_IMG_W = 416;
  localparam int DEF_IMG_H = 416;
  localparam int DEF_PIX_W = 8;

  // One pad slot on each side of the image columns.
  function automatic int row_width(input int img_w, input int pix_w);
    return (img_w + 2) * pix_w;
  endfunction

  localparam int DEF_ROW_W = row_width(DEF_IMG_W, DEF_PIX_W);

  typedef enum logic [2:0] {
    IDLE,
    TOP,
    FILL,
    EMIT,
    BOT
  } state_t;

endpackage

// File: rtl/pad_row_buffer.sv
// Three-channel, write-addressed row register with a zero pad slot on
// each side.
//   clk           : clock
//   clear         : synchronous clear of every stored sample
//   wr_en         : write the pixel on wr_r/wr_g/wr_b into column wr_col
//   wr_col        : image column 0..IMG_W-1 (lands in padded slot wr_col+1)
//   wr_r/g/b      : pixel channels
//   r_row/g_row/b_row : padded rows; slot k at [k*PIX_W +: PIX_W],
//                   slots 0 and IMG_W+1 are constant zero
module pad_row_buffer
  import pad_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int PIX_W = DEF_PIX_W,
  localparam int ROW_W = row_width(IMG_W, PIX_W),
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_col,
  input  logic [PIX_W-1:0] wr_r,
  input  logic [PIX_W-1:0] wr_g,
  input  logic [PIX_W-1:0] wr_b,
  output logic [ROW_W-1:0] r_row,
  output logic [ROW_W-1:0] g_row,
  output logic [ROW_W-1:0] b_row
);

  logic [PIX_W-1:0] r_mem [IMG_W];
  logic [PIX_W-1:0] g_mem [IMG_W];
  logic [PIX_W-1:0] b_mem [IMG_W];

  always_ff @(posedge clk) begin
    if (clear) begin
      // NOTE: this row is register-based and every slot reaches the output
      // bus, so it is cleared explicitly; a RAM-backed buffer would not be.
      for (int i = 0; i < IMG_W; i++) begin
        r_mem[i] <= '0;
        g_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (wr_en) begin
      r_mem[wr_col] <= wr_r;
      g_mem[wr_col] <= wr_g;
      b_mem[wr_col] <= wr_b;
    end
  end

  assign r_row[PIX_W-1:0]       = '0;
  assign g_row[PIX_W-1:0]       = '0;
  assign b_row[PIX_W-1:0]       = '0;
  assign r_row[ROW_W-1 -: PIX_W] = '0;
  assign g_row[ROW_W-1 -: PIX_W] = '0;
  assign b_row[ROW_W-1 -: PIX_W] = '0;

  for (genvar c = 0; c < IMG_W; c++) begin : g_slot
    assign r_row[(c+1)*PIX_W +: PIX_W] = r_mem[c];
    assign g_row[(c+1)*PIX_W +: PIX_W] = g_mem[c];
    assign b_row[(c+1)*PIX_W +: PIX_W] = b_mem[c];
  end

endmodule

// File: rtl/pad_row_builder.sv
// Builds zero-padded RGB rows for a 3x3 convolution front-end. Per frame it
// emits an all-zero top row, IMG_H image rows assembled from a raster pixel
// stream, and an all-zero bottom row.
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle pulse, begins a frame when idle
//   s_valid/s_ready     : pixel stream handshake, s_r/s_g/s_b pixel channels
//   row_valid/row_ready : padded row handshake
//   R/G/B_padded        : padded rows, slot k at [k*PIX_W +: PIX_W]
//   row_idx             : output row index 0..IMG_H+1
//   busy                : high whenever a frame is in progress
//   frame_done          : one-cycle pulse after the bottom row is accepted
module pad_row_builder
  import pad_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W,
  localparam int ROW_W = row_width(IMG_W, PIX_W),
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int IDX_W = $clog2(IMG_H + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_r,
  input  logic [PIX_W-1:0] s_g,
  input  logic [PIX_W-1:0] s_b,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [ROW_W-1:0] R_padded,
  output logic [ROW_W-1:0] G_padded,
  output logic [ROW_W-1:0] B_padded,
  output logic [IDX_W-1:0] row_idx,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(IMG_H - 1);
  localparam logic [IDX_W-1:0] BOT_IDX  = IDX_W'(IMG_H + 1);

  state_t           state;
  state_t           state_next;
  logic [COL_W-1:0] col;
  logic [IDX_W-1:0] img_row;
  logic             show_row;
  logic             in_hs;
  logic             out_hs;
  logic [ROW_W-1:0] buf_r;
  logic [ROW_W-1:0] buf_g;
  logic [ROW_W-1:0] buf_b;

  // Outputs decode the state and row registers only, so row_ready never
  // reaches row_valid or the buses combinationally.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    s_ready    = 1'b0;
    row_valid  = 1'b0;
    busy       = 1'b1;
    row_idx    = '0;
    show_row   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = TOP;
      end
      TOP: begin
        row_valid = 1'b1;
        if (row_ready) state_next = FILL;
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid && col == LAST_COL) state_next = EMIT;
      end
      EMIT: begin
        row_valid = 1'b1;
        show_row  = 1'b1;
        row_idx   = img_row + IDX_W'(1);
        if (row_ready) state_next = (img_row == LAST_ROW) ? BOT : FILL;
      end
      BOT: begin
        row_valid = 1'b1;
        row_idx   = BOT_IDX;
        if (row_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_hs  = s_valid && s_ready;
  assign out_hs = row_valid && row_ready;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      img_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= (state == BOT) && out_hs;
      if (state == TOP && out_hs) begin
        col     <= '0;
        img_row <= '0;
      end
      if (in_hs) col <= (col == LAST_COL) ? '0 : col + COL_W'(1);
      if (state == EMIT && out_hs && img_row != LAST_ROW)
        img_row <= img_row + IDX_W'(1);
    end
  end

  pad_row_buffer #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W)
  ) u_buf (
    .clk    (clk),
    .clear  (reset),
    .wr_en  (in_hs),
    .wr_col (col),
    .wr_r   (s_r),
    .wr_g   (s_g),
    .wr_b   (s_b),
    .r_row  (buf_r),
    .g_row  (buf_g),
    .b_row  (buf_b)
  );

  // Top, bottom and idle rows read as zero; only EMIT exposes the buffer.
  assign R_padded = show_row ? buf_r : '0;
  assign G_padded = show_row ? buf_g : '0;
  assign B_padded = show_row ? buf_b : '0;

endmodule

// File: tb/tb_pad_row_builder.sv
// Scoreboard bench for pad_row_builder at IMG_W=4, IMG_H=3, PIX_W=8.
// The driver pushes the expected padded row into a queue as it issues each
// row's stimulus; a monitor pops and compares on every accepted row.
module tb_pad_row_builder;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int P    = 8;
  localparam int BW   = (W + 2) * P;
  localparam int IW   = $clog2(H + 2);

  typedef struct {
    int            idx;
    logic [BW-1:0] r;
    logic [BW-1:0] g;
    logic [BW-1:0] b;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [P-1:0]  s_r, s_g, s_b;
  logic          row_valid;
  logic          row_ready;
  logic [BW-1:0] R_padded, G_padded, B_padded;
  logic [IW-1:0] row_idx;
  logic          busy;
  logic          frame_done;

  exp_t          exp_q[$];
  int            vec_cnt  = 0;
  int            miss_cnt = 0;
  int            done_seen = 0;
  bit            done_expected = 1'b0;
  bit            stall_pending = 1'b0;
  logic [BW-1:0] first_row1_r = '0;
  bit            row1_captured = 1'b0;
  logic [P-1:0]  g_off = '0;
  logic [P-1:0]  b_off = '0;

  pad_row_builder #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (P)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_r        (s_r),
    .s_g        (s_g),
    .s_b        (s_b),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .R_padded   (R_padded),
    .G_padded   (G_padded),
    .B_padded   (B_padded),
    .row_idx    (row_idx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [P-1:0] pix(input int base, input int img_row, input int c);
    return P'(base + img_row * W + c + 1);
  endfunction

  function automatic exp_t mk_row(input int idx, input int base, input int img_row, input bit zero);
    exp_t e;
    e.idx = idx;
    e.r = '0;
    e.g = '0;
    e.b = '0;
    if (!zero) begin
      for (int c = 0; c < W; c++) begin
        e.r[(c+1)*P +: P] = pix(base, img_row, c);
        e.g[(c+1)*P +: P] = pix(base, img_row, c) + g_off;
        e.b[(c+1)*P +: P] = pix(base, img_row, c) + b_off;
      end
    end
    return e;
  endfunction

  // Monitor: frame_done timing and row scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (done_expected) begin
      check("frame_done", frame_done, 1);
      if (frame_done) done_seen++;
      done_expected = 1'b0;
    end else if (frame_done) begin
      check("frame_done_spurious", frame_done, 0);
    end
    if (row_valid && row_ready) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL row_unexpected: got row_idx %0d, expected no row", row_idx);
      end else begin
        e = exp_q.pop_front();
        check("row_idx", row_idx, e.idx);
        check("R_row", R_padded, e.r);
        check("G_row", G_padded, e.g);
        check("B_row", B_padded, e.b);
        if (e.idx == 1 && !row1_captured) begin
          first_row1_r  = R_padded;
          row1_captured = 1'b1;
        end
        if (e.idx == H + 1) done_expected = 1'b1;
      end
    end
  end

  // Back-pressure: hold row 2 for ten cycles when requested.
  initial begin
    logic [BW-1:0] hr, hg, hb;
    row_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_pending && row_valid && row_idx == IW'(2)) begin
        row_ready = 1'b0;
        hr = R_padded;
        hg = G_padded;
        hb = B_padded;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("stall_valid", row_valid, 1);
          check("stall_s_ready", s_ready, 0);
          check("stall_R", R_padded, hr);
          if (G_padded !== hg || B_padded !== hb) check("stall_GB", {G_padded, B_padded}, {hg, hb});
        end
        row_ready = 1'b1;
        stall_pending = 1'b0;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_row_valid"}, row_valid, 0);
    check({tag, "_row_idx"}, row_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_buses"}, {R_padded | G_padded | B_padded}, 0);
  endtask

  task automatic push_pixel(input logic [P-1:0] v);
    bit acc;
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_r = v;
    s_g = v + g_off;
    s_b = v + b_off;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("pixel_accept_timeout", ok, 1);
  endtask

  task automatic send_row(input int base, input int img_row, input bit gaps, input bit poke);
    for (int c = 0; c < W; c++) begin
      if (gaps && $urandom_range(1, 0) == 1) begin
        s_valid = 1'b0;
        s_r = 8'hEE;
        s_g = 8'hEE;
        s_b = 8'hEE;
        repeat ($urandom_range(2, 1)) @(posedge clk);
        #1;
      end
      push_pixel(pix(base, img_row, c));
      if (poke && c == 1) begin
        s_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    exp_q.push_back(mk_row(img_row + 1, base, img_row, 1'b0));
    check("emit_latency_valid", row_valid, 1);
    check("emit_latency_idx", row_idx, img_row + 1);
  endtask

  task automatic begin_frame();
    exp_q.push_back(mk_row(0, 0, 0, 1'b1));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("top_busy", busy, 1);
    check("top_valid", row_valid, 1);
    check("top_idx", row_idx, 0);
  endtask

  task automatic run_frame(input int base, input bit gaps, input int poke_row, input bit stall);
    int target;
    bit reached = 1'b0;
    target = done_seen + 1;
    stall_pending = stall;
    begin_frame();
    for (int r = 0; r < H; r++) send_row(base, r, gaps, r == poke_row);
    exp_q.push_back(mk_row(H + 1, 0, 0, 1'b1));
    s_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (done_seen >= target) begin
        reached = 1'b1;
        break;
      end
    end
    check("frame_end_reached", reached, 1);
    @(posedge clk);
    #1;
    check("post_frame_busy", busy, 0);
    check("post_frame_queue", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_r = '0;
    s_g = '0;
    s_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Frame 0: R=G=B, free-flowing downstream.
    run_frame(0, 1'b0, -1, 1'b0);
    check("row1_literal", first_row1_r, 48'h00_04_03_02_01_00);

    // Frame 1: row 2 held for ten cycles.
    g_off = 8'h30;
    b_off = 8'h60;
    run_frame(8'h20, 1'b0, -1, 1'b1);

    // Frame 2: gappy s_valid plus a start pulse inside FILL.
    run_frame(8'h40, 1'b1, 1, 1'b0);

    // Frame 3: reset after two pixels of padded row 1.
    begin_frame();
    push_pixel(pix(8'h60, 0, 0));
    push_pixel(pix(8'h60, 0, 1));
    s_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_outputs("abort");
    check("abort_queue", exp_q.size(), 0);

    // Frame 4: clean frame after the abort.
    run_frame(8'h80, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
